// File: rtl/mhd_seq_checker_if.sv
// Job/result handshake bundle for mhd_seq_checker.
// master: job producer / result consumer (drives in_valid, a, b, thresh, out_ready).
// slave:  the checker (drives in_ready, out_valid, out_f, out_sum, out_early, busy).
interface mhd_seq_checker_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] thresh;
  logic             out_valid;
  logic             out_ready;
  logic             out_f;
  logic [CNT_W-1:0] out_sum;
  logic             out_early;
  logic             busy;

  modport master (
    output in_valid, a, b, thresh, out_ready,
    input  in_ready, out_valid, out_f, out_sum, out_early, busy
  );

  modport slave (
    input  in_valid, a, b, thresh, out_ready,
    output in_ready, out_valid, out_f, out_sum, out_early, busy
  );
endinterface

// File: rtl/mhd_seq_checker.sv
// Sequential Hamming-distance threshold checker: f = popcount(a^b) > thresh,
// popcounting CHUNK bits of the difference per SCAN cycle with one small adder.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the job
// handshake (in_valid/in_ready, a, b, thresh), the result handshake
// (out_valid/out_ready, out_f, out_sum, out_early) and the busy flag.
// The interface instance must be built with the same WIDTH and CNT_W.
module mhd_seq_checker #(
  parameter int WIDTH      = 18,
  parameter int CHUNK      = 3,
  parameter int CNT_W      = 6,
  parameter int EARLY_EXIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  mhd_seq_checker_if.slave    bus
);

  localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  // The count must be able to hold a full-width distance.
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("mhd_seq_checker: CNT_W too small for WIDTH");
  end
  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("mhd_seq_checker: CHUNK must be in 1..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   diff;
  logic [CNT_W-1:0]   thresh_l;
  logic [CNT_W-1:0]   cnt;
  logic [BEAT_W-1:0]  beat;
  logic [CNT_W-1:0]   chunk_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               last_beat;
  logic               over;
  logic               stop;
  logic               res_f;
  logic [CNT_W-1:0]   res_sum;
  logic               res_early;

  // Popcount of the low chunk; bits above the operand are already zero
  // because the shift register fills with zeros, which pads the last chunk.
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_cnt = chunk_cnt + CNT_W'(diff[i]);
    end
    cnt_next  = cnt + chunk_cnt;
    last_beat = (beat == BEAT_W'(NBEATS - 1));
    over      = (cnt_next > thresh_l);
    stop      = last_beat || ((EARLY_EXIT != 0) && over);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = SCAN;
      SCAN:    if (stop)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff      <= '0;
      thresh_l  <= '0;
      cnt       <= '0;
      beat      <= '0;
      res_f     <= 1'b0;
      res_sum   <= '0;
      res_early <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            diff     <= bus.a ^ bus.b;
            thresh_l <= bus.thresh;
            cnt      <= '0;
            beat     <= '0;
          end
        end
        SCAN: begin
          cnt  <= cnt_next;
          diff <= diff >> CHUNK;
          beat <= beat + BEAT_W'(1);
          if (stop) begin
            res_sum   <= cnt_next;
            res_f     <= over;
            // Exceeding on the final beat is a full scan, not an early exit.
            res_early <= !last_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by rst so no job can appear accepted while reset is held.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_f     = res_f;
  assign bus.out_sum   = res_sum;
  assign bus.out_early = res_early;

endmodule
